// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory behind the MEM-stage access port.
// Each access holds `stall` for LAT cycles (IDLE + LAT-1 BUSY), then commits in
// one DONE cycle. Optional build macro DMEM_ADDR_CHECK_EN adds range checking
// and a sticky addr_err output.
module data_mem_responder #(
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_res,
  input  logic [31:0] ST_value,
  output logic [31:0] dataMem_out,
  output logic        stall
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_wr;
  logic [31:0]      r_mem [DEPTH];

  logic             w_req;
  logic             w_commit;
  logic [31:0]      w_a;
  logic [31:0]      w_d;
  logic             w_wr;
  logic [31:0]      w_off;
  logic [IDXW-1:0]  w_idx;
  logic             w_ok;

  assign w_req = MEM_R_EN | MEM_W_EN;

  // The edge entering DONE commits the access. With LAT=1 that edge is the
  // IDLE edge itself, so operands come straight from the inputs there.
  assign w_commit = ((r_state == S_IDLE) && w_req && (LAT == 1)) ||
                    ((r_state == S_BUSY) && (r_cnt <= 4'd1));
  assign w_a  = (r_state == S_IDLE) ? ALU_res  : r_addr;
  assign w_d  = (r_state == S_IDLE) ? ST_value : r_wdata;
  assign w_wr = (r_state == S_IDLE) ? MEM_W_EN : r_wr;

  // Word index wraps modulo DEPTH; low two address bits drop out.
  assign w_off = w_a - 32'(BASE_ADDR);
  assign w_idx = IDXW'(w_off >> 2);

`ifdef DMEM_ADDR_CHECK_EN
  assign w_ok = (w_a[1:0] == 2'b00) &&
                ({1'b0, w_a} >= 33'(BASE_ADDR)) &&
                ({1'b0, w_a} <  33'(BASE_ADDR) + 33'(4 * DEPTH));
`else
  assign w_ok = 1'b1;
`endif

  // Freeze the pipeline from the request cycle through BUSY; reset drops it
  // immediately even while a request is still presented.
  assign stall = rst & (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));

  // Access sequencer: capture operands in IDLE, count latency in BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wr    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= ALU_res;
            r_wdata <= ST_value;
            r_wr    <= MEM_W_EN;
            r_cnt   <= 4'(LAT - 1);
            r_state <= (LAT == 1) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array, read register and error flag update only on the commit edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'd0;
      dataMem_out <= 32'd0;
`ifdef DMEM_ADDR_CHECK_EN
      addr_err    <= 1'b0;
`endif
    end else if (w_commit) begin
      if (w_wr) begin
        if (w_ok) r_mem[w_idx] <= w_d;
      end else begin
        dataMem_out <= w_ok ? r_mem[w_idx] : 32'd0;
      end
`ifdef DMEM_ADDR_CHECK_EN
      if (!w_ok) addr_err <= 1'b1;
`endif
    end
  end

endmodule
